// File: rtl/svm_decision_funct_if.sv
// Bus bundle for the SVM decision-function engine: start request, pixel stream,
// coefficients in, and the decision result out.
interface svm_decision_funct_if #(
    parameter int XLEN_PIXEL    = 8,
    parameter int NUM_OF_PIXELS = 784,
    parameter int NUM_OF_SV     = 10,
    parameter int ALPHA_W       = 16
);
    localparam int ACC_W = 2*XLEN_PIXEL + $clog2(NUM_OF_PIXELS);
    localparam int F_W   = ACC_W + ALPHA_W + $clog2(NUM_OF_SV) + 1;

    logic                  en;
    logic                  in_valid;
    logic                  in_ready;
    logic [XLEN_PIXEL-1:0] x_pixel;
    logic [XLEN_PIXEL-1:0] sv_pixel;
    logic [ALPHA_W-1:0]    alpha_in;
    logic [ALPHA_W-1:0]    bias;
    logic                  busy;
    logic                  done;
    logic [F_W-1:0]        dec_value;
    logic                  class_out;

    modport master (
        output en, in_valid, x_pixel, sv_pixel, alpha_in, bias,
        input  in_ready, busy, done, dec_value, class_out
    );

    modport slave (
        input  en, in_valid, x_pixel, sv_pixel, alpha_in, bias,
        output in_ready, busy, done, dec_value, class_out
    );
endinterface

// File: rtl/svm_decision_funct.sv
// Linear-kernel SVM decision function: f = sum_k alpha_k * <x, sv_k> + bias,
// streamed one pixel pair per accepted beat, result and sign class held until the next run.
module svm_decision_funct #(
    parameter int XLEN_PIXEL    = 8,
    parameter int NUM_OF_PIXELS = 784,
    parameter int NUM_OF_SV     = 10,
    parameter int ALPHA_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    svm_decision_funct_if.slave  bus
);
    localparam int ACC_W  = 2*XLEN_PIXEL + $clog2(NUM_OF_PIXELS);
    localparam int F_W    = ACC_W + ALPHA_W + $clog2(NUM_OF_SV) + 1;
    localparam int PROD_W = 2*XLEN_PIXEL;
    localparam int TERM_W = ALPHA_W + ACC_W + 1;
    localparam int PIX_CW = $clog2(NUM_OF_PIXELS + 1);
    localparam int SV_CW  = $clog2(NUM_OF_SV + 1);
    localparam logic [PIX_CW-1:0] PIX_LAST = PIX_CW'(NUM_OF_PIXELS - 1);
    localparam logic [SV_CW-1:0]  SV_LAST  = SV_CW'(NUM_OF_SV - 1);

    typedef enum logic [2:0] {IDLE, ACCUM, SCALE, BIAS, DONE} state_t;

    state_t                    state, state_n;
    logic [PIX_CW-1:0]         pix_cnt;
    logic [SV_CW-1:0]          sv_cnt;
    logic [ACC_W-1:0]          dot;
    logic signed [F_W-1:0]     fsum;
    logic signed [ALPHA_W-1:0] alpha_q;
    logic signed [F_W-1:0]     dec_q;
    logic                      class_q;

    logic                      in_ready_c, busy_c, done_c;
    logic                      beat;
    logic [PROD_W-1:0]         pix_prod;
    logic signed [TERM_W-1:0]  sv_term;
    logic signed [F_W-1:0]     fsum_bias;

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n    = state;
        in_ready_c = 1'b0;
        busy_c     = 1'b1;
        done_c     = 1'b0;
        case (state)
            IDLE: begin
                busy_c = 1'b0;
                if (bus.en) state_n = ACCUM;
            end
            ACCUM: begin
                in_ready_c = 1'b1;
                if (bus.in_valid && pix_cnt == PIX_LAST) state_n = SCALE;
            end
            SCALE:   state_n = (sv_cnt == SV_LAST) ? BIAS : ACCUM;
            BIAS:    state_n = DONE;
            DONE: begin
                done_c  = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        beat      = in_ready_c && bus.in_valid;
        pix_prod  = PROD_W'(bus.x_pixel) * PROD_W'(bus.sv_pixel);
        // {0,dot} keeps the unsigned dot product positive in the signed multiply
        sv_term   = TERM_W'(alpha_q) * TERM_W'($signed({1'b0, dot}));
        fsum_bias = fsum + F_W'($signed(bus.bias));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pix_cnt <= '0;
            sv_cnt  <= '0;
            dot     <= '0;
            fsum    <= '0;
            alpha_q <= '0;
            dec_q   <= '0;
            class_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.en) begin
                    pix_cnt <= '0;
                    sv_cnt  <= '0;
                    dot     <= '0;
                    fsum    <= '0;
                end
                ACCUM: if (beat) begin
                    dot     <= dot + ACC_W'(pix_prod);
                    pix_cnt <= pix_cnt + PIX_CW'(1);
                    if (pix_cnt == PIX_LAST) alpha_q <= $signed(bus.alpha_in);
                end
                SCALE: begin
                    fsum    <= fsum + F_W'(sv_term);
                    dot     <= '0;
                    pix_cnt <= '0;
                    if (sv_cnt != SV_LAST) sv_cnt <= sv_cnt + SV_CW'(1);
                end
                // Result registers load on the edge into DONE so they are valid with the done pulse.
                BIAS: begin
                    fsum    <= fsum_bias;
                    dec_q   <= fsum_bias;
                    class_q <= ~fsum_bias[F_W-1];
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.busy      = busy_c;
    assign bus.done      = done_c;
    assign bus.dec_value = dec_q;
    assign bus.class_out = class_q;
endmodule
